// File: rtl/cache.sv
// N-way set-associative, write-through, no-write-allocate data cache with true-LRU replacement.
// Define CACHE_STATS_EN to add the read hit/miss counters and their output ports.
module cache #(
  parameter int RAM_ADDRESS_BITS   = 32,
  parameter int CACHE_ADDRESS_BITS = 8,
  parameter int DATA_BITS          = 32,
  parameter int ASOC_BITS          = 2,
  parameter int BLOCK_BITS         = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0] address,
  input  logic                        read_en,
  input  logic [DATA_BITS-1:0]        write_data,
  input  logic                        write_en,
  input  logic                        ram_valid,
  input  logic [DATA_BITS-1:0]        ram_data [2**BLOCK_BITS],
  output logic [DATA_BITS-1:0]        read_data,
  output logic                        valid,
  output logic                        miss,
  output logic [RAM_ADDRESS_BITS-1:0] prop_address,
  output logic                        prop_read_en,
  output logic [DATA_BITS-1:0]        prop_write_data,
  output logic                        prop_write_en
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  localparam int unsigned WORDS     = 2**BLOCK_BITS;
  localparam int unsigned WAYS      = 2**ASOC_BITS;
  localparam int          SETS_BITS = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
  localparam int unsigned SETS      = 2**SETS_BITS;
  localparam int          TAG_BITS  = RAM_ADDRESS_BITS - SETS_BITS - BLOCK_BITS;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e state_q, state_d;

  logic [BLOCK_BITS-1:0] req_off, lat_off;
  logic [SETS_BITS-1:0]  req_idx, lat_idx;
  logic [TAG_BITS-1:0]   req_tag, lat_tag;

  logic [RAM_ADDRESS_BITS-1:0] lat_addr_q, lat_addr_d;

  logic [WAYS-1:0]      line_valid_q [SETS];
  logic [WAYS-1:0]      line_valid_d [SETS];
  logic [TAG_BITS-1:0]  tag_q        [SETS][WAYS];
  logic [TAG_BITS-1:0]  tag_d        [SETS][WAYS];
  logic [DATA_BITS-1:0] data_q       [SETS][WAYS][WORDS];
  logic [DATA_BITS-1:0] data_d       [SETS][WAYS][WORDS];
  logic [ASOC_BITS-1:0] age_q        [SETS][WAYS];
  logic [ASOC_BITS-1:0] age_d        [SETS][WAYS];

  logic [DATA_BITS-1:0]        read_data_q, read_data_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        miss_q, miss_d;
  logic [RAM_ADDRESS_BITS-1:0] prop_address_q, prop_address_d;
  logic                        prop_read_en_q, prop_read_en_d;
  logic [DATA_BITS-1:0]        prop_write_data_q, prop_write_data_d;
  logic                        prop_write_en_q, prop_write_en_d;

  logic                 hit;
  logic [ASOC_BITS-1:0] hit_way;
  logic [ASOC_BITS-1:0] victim;
  logic                 victim_found;
  logic                 touch;
  logic [ASOC_BITS-1:0] touch_way;
  logic [SETS_BITS-1:0] touch_idx;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
`endif

  assign req_off = address[BLOCK_BITS-1:0];
  assign req_idx = address[BLOCK_BITS +: SETS_BITS];
  assign req_tag = address[RAM_ADDRESS_BITS-1 -: TAG_BITS];
  assign lat_off = lat_addr_q[BLOCK_BITS-1:0];
  assign lat_idx = lat_addr_q[BLOCK_BITS +: SETS_BITS];
  assign lat_tag = lat_addr_q[RAM_ADDRESS_BITS-1 -: TAG_BITS];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (line_valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = ASOC_BITS'(w);
      end
    end
  end

  // Ages in a set always form a permutation, so the LRU way is the one aged all-ones.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victim_found && !line_valid_q[lat_idx][w]) begin
        victim       = ASOC_BITS'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[lat_idx][w] == '1) victim = ASOC_BITS'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!write_en && read_en && !hit) state_d = REFILL;
      REFILL:  if (ram_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_data_d       = read_data_q;
    rd_valid_d        = 1'b0;
    miss_d            = miss_q;
    prop_address_d    = prop_address_q;
    prop_read_en_d    = prop_read_en_q;
    prop_write_data_d = prop_write_data_q;
    prop_write_en_d   = 1'b0;
    lat_addr_d        = lat_addr_q;
    line_valid_d      = line_valid_q;
    tag_d             = tag_q;
    data_d            = data_q;
    age_d             = age_q;
    touch             = 1'b0;
    touch_way         = '0;
    touch_idx         = req_idx;
`ifdef CACHE_STATS_EN
    hit_count_d       = hit_count_q;
    miss_count_d      = miss_count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (write_en) begin
          prop_write_en_d   = 1'b1;
          prop_address_d    = address;
          prop_write_data_d = write_data;
          if (hit) begin
            data_d[req_idx][hit_way][req_off] = write_data;
            touch     = 1'b1;
            touch_way = hit_way;
          end
        end else if (read_en) begin
          if (hit) begin
            read_data_d = data_q[req_idx][hit_way][req_off];
            rd_valid_d  = 1'b1;
            touch       = 1'b1;
            touch_way   = hit_way;
`ifdef CACHE_STATS_EN
            hit_count_d = hit_count_q + 32'd1;
`endif
          end else begin
            miss_d         = 1'b1;
            prop_read_en_d = 1'b1;
            prop_address_d = address;
            read_data_d    = '0;
            lat_addr_d     = address;
`ifdef CACHE_STATS_EN
            miss_count_d   = miss_count_q + 32'd1;
`endif
          end
        end
      end
      REFILL: begin
        if (ram_valid) begin
          line_valid_d[lat_idx][victim] = 1'b1;
          tag_d[lat_idx][victim]        = lat_tag;
          for (int unsigned k = 0; k < WORDS; k++) data_d[lat_idx][victim][k] = ram_data[k];
          read_data_d    = ram_data[lat_off];
          rd_valid_d     = 1'b1;
          miss_d         = 1'b0;
          prop_read_en_d = 1'b0;
          touch          = 1'b1;
          touch_way      = victim;
          touch_idx      = lat_idx;
        end
      end
      default: ;
    endcase
    if (touch) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[touch_idx][w] < age_q[touch_idx][touch_way])
          age_d[touch_idx][w] = age_q[touch_idx][w] + 1'b1;
      end
      age_d[touch_idx][touch_way] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      read_data_q       <= '0;
      rd_valid_q        <= 1'b0;
      miss_q            <= 1'b0;
      prop_address_q    <= '0;
      prop_read_en_q    <= 1'b0;
      prop_write_data_q <= '0;
      prop_write_en_q   <= 1'b0;
      lat_addr_q        <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        line_valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= ASOC_BITS'(w);
      end
`ifdef CACHE_STATS_EN
      hit_count_q       <= '0;
      miss_count_q      <= '0;
`endif
    end else begin
      read_data_q       <= read_data_d;
      rd_valid_q        <= rd_valid_d;
      miss_q            <= miss_d;
      prop_address_q    <= prop_address_d;
      prop_read_en_q    <= prop_read_en_d;
      prop_write_data_q <= prop_write_data_d;
      prop_write_en_q   <= prop_write_en_d;
      lat_addr_q        <= lat_addr_d;
      line_valid_q      <= line_valid_d;
      age_q             <= age_d;
`ifdef CACHE_STATS_EN
      hit_count_q       <= hit_count_d;
      miss_count_q      <= miss_count_d;
`endif
    end
  end

  // Tag and data arrays need no reset: a cleared valid bit masks their contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign read_data       = read_data_q;
  assign valid           = rd_valid_q;
  assign miss            = miss_q;
  assign prop_address    = prop_address_q;
  assign prop_read_en    = prop_read_en_q;
  assign prop_write_data = prop_write_data_q;
  assign prop_write_en   = prop_write_en_q;
`ifdef CACHE_STATS_EN
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;
`endif

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for cache: a block-level LRU model (last-use timestamps per cached block)
// predicts hits/misses; RAM contents are a sparse word map, so every read must return RAM's word.
module tb_cache;
  localparam int WORDS = 4;
  localparam int WAYS  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] address = '0;
  logic        read_en = 1'b0;
  logic [31:0] write_data = '0;
  logic        write_en = 1'b0;
  logic        ram_valid = 1'b0;
  logic [31:0] ram_data [WORDS];
  logic [31:0] read_data;
  logic        valid, miss;
  logic [31:0] prop_address;
  logic        prop_read_en;
  logic [31:0] prop_write_data;
  logic        prop_write_en;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache #(
    .RAM_ADDRESS_BITS(32), .CACHE_ADDRESS_BITS(8), .DATA_BITS(32), .ASOC_BITS(2), .BLOCK_BITS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read_en(read_en),
    .write_data(write_data), .write_en(write_en), .ram_valid(ram_valid), .ram_data(ram_data),
    .read_data(read_data), .valid(valid), .miss(miss), .prop_address(prop_address),
    .prop_read_en(prop_read_en), .prop_write_data(prop_write_data), .prop_write_en(prop_write_en)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_rd   [$];
  logic [31:0] exp_miss [$];
  logic [63:0] exp_wr   [$];

  logic [31:0] mem [logic [31:0]];
  longint      last_use [logic [31:0]];
  longint      tick = 0;
  int          m_hits = 0, m_misses = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [31:0] memrd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Insert a block; if its set already holds WAYS blocks, drop the least recently used one.
  function automatic void mdl_fill(logic [31:0] blk);
    int          cnt = 0;
    longint      oldest = -1;
    logic [31:0] old_blk = '0;
    foreach (last_use[b]) begin
      if (b[3:0] == blk[3:0]) begin
        cnt++;
        if (oldest < 0 || last_use[b] < oldest) begin
          oldest  = last_use[b];
          old_blk = b;
        end
      end
    end
    if (cnt >= WAYS) last_use.delete(old_blk);
    last_use[blk] = tick++;
  endfunction

  // Monitor: pops and compares whenever the DUT presents a result or a RAM strobe.
  logic prev_pre = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      if (exp_rd.size() == 0) flag("unexpected valid");
      else check("read_data", {32'h0, read_data}, {32'h0, exp_rd.pop_front()});
    end
    if (prop_write_en) begin
      if (exp_wr.size() == 0) flag("unexpected prop_write_en");
      else check("write_through", {prop_address, prop_write_data}, exp_wr.pop_front());
    end
    if (prop_read_en && !prev_pre) begin
      if (exp_miss.size() == 0) flag("unexpected miss");
      else begin
        check("miss_address", {32'h0, prop_address}, {32'h0, exp_miss.pop_front()});
        check("miss_state", {30'h0, miss, 1'b0, 32'h0 | (read_data != 0)}, {30'h0, 1'b1, 1'b0, 32'h0});
      end
    end
    prev_pre <= prop_read_en;
  end

  task automatic wait_prop();
    int n = 0;
    while (!prop_read_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!prop_read_en) flag("timeout waiting for prop_read_en");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1; read_en = 1'b0; write_en = 1'b0; ram_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    check("reset_outputs",
          {read_data, prop_address[15:0], 8'h0, valid, miss, prop_read_en, prop_write_en, 4'h0},
          64'h0);
    check("reset_wdata", {32'h0, prop_write_data}, 64'h0);
    last_use.delete();
    m_hits = 0; m_misses = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input bit junk);
    logic [31:0] blk = a >> 2;
    if (last_use.exists(blk)) begin
      exp_rd.push_back(memrd(a));
      last_use[blk] = tick++;
      m_hits++;
      @(negedge clk);
      address = a; read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
    end else begin
      exp_miss.push_back(a);
      exp_rd.push_back(memrd(a));
      mdl_fill(blk);
      m_misses++;
      @(negedge clk);
      address = a; read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      wait_prop();
      if (junk) begin
        address = a ^ 32'h40; write_data = $urandom; write_en = 1'b1; read_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0;
      end
      for (int k = 0; k < WORDS; k++) ram_data[k] = memrd({a[31:2], 2'(k)});
      ram_valid = 1'b1;
      @(negedge clk);
      ram_valid = 1'b0;
      for (int k = 0; k < WORDS; k++) ram_data[k] = $urandom;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit noise);
    logic [31:0] blk = a >> 2;
    exp_wr.push_back({a, d});
    mem[a] = d;
    if (last_use.exists(blk)) last_use[blk] = tick++;
    @(negedge clk);
    address = a; write_data = d; write_en = 1'b1; read_en = noise; ram_valid = noise;
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0; ram_valid = 1'b0;
  endtask

  task automatic reset_mid_refill(input logic [31:0] a);
    exp_miss.push_back(a);
    @(negedge clk);
    address = a; read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    wait_prop();
    do_reset();
    check("miss_after_abort", {63'h0, miss}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < WORDS; k++) ram_data[k] = '0;
    do_reset();

    for (int k = 0; k < WORDS; k++) mem[32'h10000 + k] = 32'd3;
    do_read(32'h10000, 1'b0);
    do_read(32'h10000, 1'b0);

    do_reset();
    do_write(32'h10000, 32'hAAAA, 1'b1);
    do_read(32'h10000, 1'b0);

    do_read(32'd10, 1'b0);
    do_write(32'd10, 32'h55, 1'b0);
    do_read(32'd10, 1'b0);
    do_read(32'd11, 1'b0);

    do_reset();
    for (int t = 1; t <= 4; t++) do_read(32'h10000 * t, 1'b0);
    do_read(32'h10000, 1'b0);
    do_read(32'h30000, 1'b0);
    do_read(32'h50000, 1'b0);
    do_read(32'h10000, 1'b0);
    do_read(32'h30000, 1'b0);
    do_read(32'h40000, 1'b0);
    do_read(32'h20000, 1'b0);

    do_read(32'h60004, 1'b1);
    reset_mid_refill(32'h70008);
    do_read(32'h70008, 1'b0);

`ifdef CACHE_STATS_EN
    do_reset();
    do_read(32'h100, 1'b0);
    do_read(32'h200, 1'b0);
    do_read(32'h100, 1'b0);
    do_read(32'h101, 1'b0);
    do_read(32'h202, 1'b0);
    @(negedge clk);
    check("stats_directed", {hit_count, miss_count}, {32'd3, 32'd2});
`endif

    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6) do_read(a, $urandom_range(0, 3) == 0);
      else do_write(a, $urandom, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
`ifdef CACHE_STATS_EN
    check("stats_random", {hit_count, miss_count}, {32'(m_hits), 32'(m_misses)});
`endif
    check("rd_queue_empty", 64'(exp_rd.size()), 64'h0);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'h0);
    check("miss_queue_empty", 64'(exp_miss.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache.md
Name: cache

Overview:
- Parameterised N-way set-associative, write-through, no-write-allocate data cache.
- Sits between a word-addressed requester and a block-wide backing RAM.
- Read hits return data after one cycle. Read misses issue one block read to RAM, wait for `ram_valid`, fill the LRU victim way, then return the word.
- Every write is propagated to RAM.

Parameters:
- `RAM_ADDRESS_BITS`, 32: word address width.
- `CACHE_ADDRESS_BITS`, 8: log2 of total cached words (256).
- `DATA_BITS`, 32: word width.
- `ASOC_BITS`, 2: log2 of ways (4 ways).
- `BLOCK_BITS`, 2: log2 of words per block (4 words). Derived `WORDS = 2**BLOCK_BITS`.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `reset_n` in 1: reset, synchronous, active-high (asserted = 1, sampled on `clk` rising edge).
- `address` in `RAM_ADDRESS_BITS`: request word address.
- `read_en` in 1: read request.
- `write_data` in `DATA_BITS`: write word.
- `write_en` in 1: write request.
- `ram_valid` in 1: RAM refill block present on `ram_data`.
- `ram_data` in `DATA_BITS` x `WORDS` (unpacked array): refill block; element i = block offset i.
- `read_data` out `DATA_BITS`: read result.
- `valid` out 1: one-cycle pulse; `read_data` is valid.
- `miss` out 1: refill pending.
- `prop_address` out `RAM_ADDRESS_BITS`: address to RAM.
- `prop_read_en` out 1: block read request to RAM.
- `prop_write_data` out `DATA_BITS`: write-through data.
- `prop_write_en` out 1: write-through strobe.

Behaviour:
- Address split:
  - offset = `address[BLOCK_BITS-1:0]`.
  - index = next `SETS_BITS = CACHE_ADDRESS_BITS-ASOC_BITS-BLOCK_BITS` bits (16 sets).
  - tag = remaining upper bits.
- Storage per way/set: valid bit, tag, `WORDS` data words. LRU age per way (`ASOC_BITS` bits).
- Reset:
  - All valid bits cleared.
  - LRU ages initialised to way index.
  - FSM goes to IDLE.
  - All outputs 0.
  - Reset during REFILL aborts the refill; no fill happens.
- FSM states: IDLE, REFILL.
- IDLE, requests sampled each rising edge:
  - `write_en` has priority over `read_en`; a simultaneous read is dropped.
- Write, next cycle:
  - `prop_write_en`=1 for one cycle; `prop_address`=address; `prop_write_data`=`write_data`.
  - On hit the way's word is updated and that way becomes MRU.
  - On miss there is no allocation and cache state is unchanged.
  - `valid` stays 0.
- Read hit, next cycle:
  - `read_data`=word; `valid`=1 for one cycle.
  - The hit way becomes MRU.
- Read miss, next cycle:
  - `miss`=1, `prop_read_en`=1, `prop_address`=request address; `read_data`=0, `valid`=0.
  - Address is latched; go to REFILL.
- REFILL:
  - `miss`, `prop_read_en` and `prop_address` are held; `read_en`/`write_en` are ignored.
  - On `ram_valid`=1, the victim way is the lowest-index invalid way, else the LRU way (max age).
  - Victim is written with the whole block, the latched tag and valid=1, and becomes MRU.
  - Next cycle: `read_data`=`ram_data`[latched offset], `valid`=1, `miss`=0, `prop_read_en`=0; go to IDLE.
  - No dirty state exists, so eviction needs no writeback.
- LRU update on access to way w: ages lower than age(w) increment; age(w)=0.
- Strobe and data defaults:
  - `ram_valid` in IDLE is ignored.
  - `prop_write_en` and `valid` default to 0 every cycle not explicitly pulsed.
  - `read_data` holds its last value except that a miss drives it 0.
- All outputs are registered.

Optional Feature:
- Macro `CACHE_STATS_EN`.
- Defined:
  - Adds outputs `hit_count` and `miss_count`, each 32 bits, wrapping.
  - They increment on each read hit and read miss respectively; writes are not counted.
  - Reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Post-reset read of 0x10000:
  - Next cycle: `miss`=1, `prop_read_en`=1, `prop_address`=0x10000, `read_data`=0.
  - `ram_valid` with all words 3 gives `read_data`=3, `valid`=1, `miss`=0.
  - A repeat read of 0x10000 hits: `read_data`=3 after 1 cycle, `prop_read_en`=0.
- Write 0xAAAA to 0x10000 when it is not cached:
  - `prop_write_en`=1, `prop_write_data`=0xAAAA.
  - A following read of 0x10000 still misses (no write-allocate).
  - `ram_valid` during the write cycle is ignored.
- Write 0x55 to address 10 after the 10/11 block is filled:
  - Read 10 hits with 0x55; read 11 returns the refill word.
  - `prop_write_en` pulses once.
- LRU eviction:
  - Fill 0x10000, 0x20000, 0x30000, 0x40000 (all set 0).
  - Re-read 0x10000 and 0x30000, then fill 0x50000: 0x20000 is evicted.
  - Re-reads of 0x10000, 0x30000 and 0x40000 still hit; 0x20000 misses.
- During REFILL, assert `write_en` and `read_en` to another address: both ignored, no `prop_write_en`. Assert reset mid-REFILL: `miss`=0 and a later read of the same address misses.
- With `CACHE_STATS_EN` defined, 2 misses and 3 hits give `miss_count`=2 and `hit_count`=3.
